// File: rtl/gascon_round_sched.sv
// rtl/gascon_round_sched.sv - round-robin scheduler time-sharing one Gascon round core
// Optional core_done watchdog enabled by defining GASSCHED_TIMEOUT_EN.
module gascon_round_sched #(
  parameter int CWIDTH  = 128,
  parameter int NREQ    = 2,
  parameter int RWIDTH  = 4,
  parameter int TMO_CYC = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*CWIDTH-1:0]     req_c,
  input  logic [NREQ*RWIDTH-1:0]     req_rounds,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NREQ)-1:0]    resp_id,
  output logic [CWIDTH-1:0]          resp_c,
  output logic                       resp_err,
  output logic [CWIDTH-1:0]          core_c,
  output logic [RWIDTH-1:0]          core_round,
  output logic                       core_rst,
  input  logic [CWIDTH-1:0]          core_cout,
  input  logic                       core_done
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TMO_CYC + 1);

`ifdef GASSCHED_TIMEOUT_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       id_q, id_d;
  logic [CWIDTH-1:0]   work_q, work_d;
  logic [RWIDTH-1:0]   tgt_q, tgt_d;
  logic [RWIDTH-1:0]   cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [TW-1:0]       tmo_q, tmo_d;

  logic                gnt_found;
  logic [IW-1:0]       gnt_idx;
  logic [RWIDTH-1:0]   gnt_rounds;
  logic [RWIDTH-1:0]   cnt_inc;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest valid index at/after rr_ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[wrap_add(rr_ptr_q, i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  assign gnt_rounds = req_rounds[gnt_idx*RWIDTH +: RWIDTH];
  assign cnt_inc    = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    work_d     = work_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    req_ready  = '0;
    resp_valid = 1'b0;
    resp_id    = '0;
    resp_c     = '0;
    resp_err   = 1'b0;
    core_rst   = 1'b1;
    core_c     = '0;
    core_round = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          work_d  = req_c[gnt_idx*CWIDTH +: CWIDTH];
          tgt_d   = (gnt_rounds == '0) ? RWIDTH'(1) : gnt_rounds;
          id_d    = gnt_idx;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        core_c     = work_q;
        core_round = cnt_q;
        tmo_d      = '0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        core_rst   = 1'b0;
        core_c     = work_q;
        core_round = cnt_q;
        if (core_done) begin
          work_d  = core_cout;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == tgt_q) ? S_RESP : S_LOAD;
        end else if (WDOG_EN) begin
          // work_q still holds the last completed round, which is what gets returned.
          if (tmo_q == TW'(TMO_CYC - 1)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_c     = work_q;
        resp_id    = id_q;
        resp_err   = WDOG_EN & err_q;
        if (resp_ready) begin
          err_d    = 1'b0;
          rr_ptr_d = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      work_q   <= '0;
      tgt_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      work_q   <= work_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_gascon_round_sched.sv
// tb/tb_gascon_round_sched.sv - randomized self-checking bench with a behavioural core and reference
module tb_gascon_round_sched;

  localparam int CW  = 128;
  localparam int NR  = 2;
  localparam int RW  = 4;
  localparam int TMO = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*CW-1:0]  req_c = '0;
  logic [NR*RW-1:0]  req_rounds = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [0:0]        resp_id;
  logic [CW-1:0]     resp_c;
  logic              resp_err;
  logic [CW-1:0]     core_c;
  logic [RW-1:0]     core_round;
  logic              core_rst;
  logic [CW-1:0]     core_cout = '0;
  logic              core_done = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int ptr = 0;
  int run_starts = 0;
  int rounds_q[$];
  bit stuck = 1'b0;
  int mc = 0;
  int lat = 1;
  logic prev_rst = 1'b1;

  gascon_round_sched #(.CWIDTH(CW), .NREQ(NR), .RWIDTH(RW), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_c(req_c), .req_rounds(req_rounds),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_c(resp_c), .resp_err(resp_err),
    .core_c(core_c), .core_round(core_round), .core_rst(core_rst),
    .core_cout(core_cout), .core_done(core_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in for one Gascon core round: an arbitrary keyed mixing function.
  function automatic logic [CW-1:0] core_f(input logic [CW-1:0] c, input logic [RW-1:0] r);
    return ({c[120:0], c[127:121]} ^ {c[63:0], c[127:64]} ^ (c & {c[0], c[127:1]}) ^ {32{r}})
           + 128'h9e3779b97f4a7c15f39cc0605cedc834;
  endfunction

  function automatic logic [CW-1:0] ref_perm(input logic [CW-1:0] c, input int n);
    logic [CW-1:0] v;
    v = c;
    for (int i = 0; i < n; i++) v = core_f(v, RW'(i));
    return v;
  endfunction

  function automatic int exp_grant(input logic [NR-1:0] mask);
    for (int i = 0; i < NR; i++)
      if (mask[(ptr + i) % NR]) return (ptr + i) % NR;
    return -1;
  endfunction

  function automatic logic [CW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Behavioural core: random latency per round, done for exactly one cycle.
  always @(negedge clk) begin
    if (core_rst) begin
      mc = 0;
      core_done = 1'b0;
      lat = $urandom_range(1, 4);
    end else if (stuck) begin
      core_done = 1'b0;
    end else begin
      mc++;
      core_done = (mc == lat);
      core_cout = core_f(core_c, core_round);
    end
  end

  always @(negedge clk) begin
    if (prev_rst && !core_rst) begin
      run_starts++;
      rounds_q.push_back(int'(core_round));
    end
    prev_rst = core_rst;
  end

  task automatic do_job(input logic [NR-1:0] mask, input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                        input logic [CW-1:0] c0, input logic [CW-1:0] c1, input bit keep, input int dly);
    int g;
    int eff;
    int to;
    bit ok;
    logic [CW-1:0] exp_c;
    logic [RW-1:0] rr;
    g = exp_grant(mask);
    req_valid  = mask;
    req_c      = {c1, c0};
    req_rounds = {r1, r0};
    to = 0;
    #1;
    while (req_ready == '0 && to < 200) begin
      @(negedge clk);
      #1;
      to++;
    end
    check("grant", CW'(req_ready), CW'(2'b01 << g));
    run_starts = 0;
    rounds_q.delete();
    @(negedge clk);
    if (!keep) req_valid = '0;
    rr    = (g == 1) ? r1 : r0;
    eff   = (rr == 0) ? 1 : int'(rr);
    exp_c = ref_perm((g == 1) ? c1 : c0, eff);
    to = 0;
    while (!resp_valid && to < 2000) begin
      @(negedge clk);
      to++;
    end
    check("resp_valid", CW'(resp_valid), CW'(1));
    check("resp_id", CW'(resp_id), CW'(g));
    check("resp_c", resp_c, exp_c);
    check("resp_err", CW'(resp_err), CW'(0));
    check("run_count", CW'(run_starts), CW'(eff));
    ok = (rounds_q.size() == eff);
    foreach (rounds_q[i]) if (rounds_q[i] != i) ok = 1'b0;
    check("round_seq", CW'(ok), CW'(1));
    if (dly > 0) begin
      repeat (dly) @(negedge clk);
      check("resp_hold", CW'(resp_valid), CW'(1));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_drop", CW'(resp_valid), CW'(0));
    ptr = (g + 1) % NR;
  endtask

  initial begin
    int to;
    bit seen;
    logic [CW-1:0] c0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", CW'(req_ready), CW'(0));
    check("rst_resp_valid", CW'(resp_valid), CW'(0));
    check("rst_resp_id", CW'(resp_id), CW'(0));
    check("rst_resp_c", resp_c, '0);
    check("rst_resp_err", CW'(resp_err), CW'(0));
    check("rst_core_rst", CW'(core_rst), CW'(1));
    check("rst_core_c", core_c, '0);
    check("rst_core_round", CW'(core_round), CW'(0));
    reset = 1'b1;
    @(negedge clk);

    do_job(2'b01, 4'd1, 4'd0, 128'h0123456789abcdef0123456789abcdef, '0, 1'b0, 0);
    do_job(2'b10, 4'd0, 4'd3, '0, rnd128(), 1'b0, 2);
    for (int k = 0; k < 4; k++) do_job(2'b11, 4'd2, 4'd1, rnd128(), rnd128(), 1'b1, k);
    req_valid = '0;
    do_job(2'b01, 4'd0, 4'd0, rnd128(), rnd128(), 1'b0, 0);

    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid || req_ready != '0) seen = 1'b1;
    end
    check("idle_quiet", CW'(seen), CW'(0));

    for (int k = 0; k < 12; k++)
      do_job(NR'($urandom_range(1, 3)), RW'($urandom_range(0, 5)), RW'($urandom_range(0, 5)),
             rnd128(), rnd128(), 1'b0, $urandom_range(0, 3));

    // Reset during RUN of round index 1.
    req_valid  = 2'b01;
    req_rounds = {4'd0, 4'd3};
    req_c      = {rnd128(), rnd128()};
    to = 0;
    #1;
    while (req_ready == '0 && to < 200) begin
      @(negedge clk);
      #1;
      to++;
    end
    @(negedge clk);
    req_valid = '0;
    to = 0;
    while (!(core_rst == 1'b0 && core_round == 4'd1) && to < 200) begin
      @(negedge clk);
      to++;
    end
    check("t5_reach_round2", CW'(to < 200), CW'(1));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t5_resp_valid", CW'(resp_valid), CW'(0));
    check("t5_core_rst", CW'(core_rst), CW'(1));
    check("t5_core_round", CW'(core_round), CW'(0));
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("t5_no_resp", CW'(seen), CW'(0));
    ptr = 0;
    do_job(2'b11, 4'd1, 4'd1, rnd128(), rnd128(), 1'b0, 0);

    // Core that never finishes.
    stuck = 1'b1;
    c0 = rnd128();
    req_valid  = 2'b01;
    req_rounds = {4'd0, 4'd2};
    req_c      = {128'h0, c0};
    @(negedge clk);
    req_valid = '0;
`ifdef GASSCHED_TIMEOUT_EN
    to = 0;
    while (!resp_valid && to < 4 * TMO) begin
      @(negedge clk);
      to++;
    end
    check("t6_resp_valid", CW'(resp_valid), CW'(1));
    check("t6_resp_err", CW'(resp_err), CW'(1));
    check("t6_resp_c", resp_c, c0);
    check("t6_wait_ge_tmo", CW'(to >= TMO), CW'(1));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("t6_err_clear", CW'(resp_err), CW'(0));
`else
    seen = 1'b0;
    repeat (3 * TMO) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("t6_no_resp", CW'(seen), CW'(0));
    check("t6_resp_err", CW'(resp_err), CW'(0));
`endif
    stuck = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ptr = 0;
    do_job(2'b10, 4'd0, 4'd2, rnd128(), rnd128(), 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
